// File: rtl/hazard_scoreboard_if.sv
// Hazard-unit bus: pipeline register/control taps in, forward/stall/multicycle status out.
interface hazard_scoreboard_if #(
    parameter int REGW = 5,
    parameter int SCW  = 16
);
    logic [REGW-1:0] rsD, rtD, rsE, rtE;
    logic [REGW-1:0] writeregE, writeregM, writeregW;
    logic            regwriteE, regwriteM, regwriteW;
    logic            memtoregE, memtoregM, branchD, jumpD;
    logic            mdD, mdstartE;

    logic            forwardaD, forwardbD;
    logic [1:0]      forwardaE, forwardbE;
    logic            stallF, stallD, flushE;
    logic            mdbusy, mddone;
    logic [REGW-1:0] mdwritereg;
    logic [SCW-1:0]  stallcnt;

    // Pipeline side drives the taps and observes the controls.
    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jumpD, mdD, mdstartE,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
               stallF, stallD, flushE, mdbusy, mddone, mdwritereg, stallcnt
    );

    // Hazard unit consumes the taps and produces the controls.
    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jumpD, mdD, mdstartE,
        output forwardaD, forwardbD, forwardaE, forwardbE,
               stallF, stallD, flushE, mdbusy, mddone, mdwritereg, stallcnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: forwarding selects, load/branch/multicycle stalls,
// a one-deep multicycle-unit scoreboard and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REGW  = 5,
    parameter int MDLAT = 4,
    parameter int SCW   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hazard_scoreboard_if.slave    bus
);
    logic            busy_q, busy_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [REGW-1:0] wr_q, wr_d;
    logic [SCW-1:0]  sc_q, sc_d;

    logic mddone, stall;
    logic lwstall, brstall, mdissuestall, mdpendstall, mdstructstall;

    // E-stage ALU operand select; M beats W, r0 never forwards.
    function automatic logic [1:0] fwd_e(input logic [REGW-1:0] rs,
                                         input logic [REGW-1:0] wm, input logic rwm,
                                         input logic [REGW-1:0] ww, input logic rww);
        if (rs == '0)             return 2'b00;
        if (rwm && rs == wm)      return 2'b10;
        if (rww && rs == ww)      return 2'b01;
        return 2'b00;
    endfunction

    assign mddone = busy_q && (cnt_q == 4'd0);

    // Forwarding selects and the five stall sources.
    always_comb begin
        bus.forwardaD = (bus.rsD != '0) && (bus.rsD == bus.writeregM) && bus.regwriteM;
        bus.forwardbD = (bus.rtD != '0) && (bus.rtD == bus.writeregM) && bus.regwriteM;
        bus.forwardaE = fwd_e(bus.rsE, bus.writeregM, bus.regwriteM, bus.writeregW, bus.regwriteW);
        bus.forwardbE = fwd_e(bus.rtE, bus.writeregM, bus.regwriteM, bus.writeregW, bus.regwriteW);

        lwstall = bus.memtoregE && ((bus.rtE == bus.rsD) || (bus.rtE == bus.rtD));
        brstall = bus.branchD &&
                  ((bus.regwriteE && ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD))) ||
                   (bus.memtoregM && ((bus.writeregM == bus.rsD) || (bus.writeregM == bus.rtD))));
        mdissuestall = bus.mdstartE && (bus.writeregE != '0) &&
                       ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD));
        // Held through the done cycle: the result is not in the register file yet.
        mdpendstall = busy_q && (wr_q != '0) && ((wr_q == bus.rsD) || (wr_q == bus.rtD));
        mdstructstall = bus.mdD && busy_q && !mddone;

        stall       = lwstall | brstall | mdissuestall | mdpendstall | mdstructstall;
        bus.stallD  = stall;
        bus.stallF  = stall;
        bus.flushE  = stall | bus.jumpD;
        bus.mdbusy  = busy_q;
        bus.mddone  = mddone;
        bus.mdwritereg = wr_q;
        bus.stallcnt   = sc_q;
    end

    // Next state: a new issue overrides completion; counter saturates.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        wr_d   = wr_q;
        sc_d   = sc_q;
        if (bus.mdstartE) begin
            busy_d = 1'b1;
            cnt_d  = 4'(MDLAT - 1);
            wr_d   = bus.writeregE;
        end else if (mddone) begin
            busy_d = 1'b0;
        end else if (busy_q && cnt_q != 4'd0) begin
            cnt_d  = cnt_q - 4'd1;
        end
        if (stall && sc_q != {SCW{1'b1}})
            sc_d = sc_q + 1'b1;
    end

    // State registers; reset abandons any op in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
            wr_q   <= '0;
            sc_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            wr_q   <= wr_d;
            sc_q   <= sc_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: behavioural model pushes expected outputs per
// vector, popped and compared at the falling edge. A second instance with a
// 2-bit stall counter shares the stimulus to exercise saturation.
module tb_hazard_scoreboard;
    localparam int REGW  = 5;
    localparam int MDLAT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REGW(REGW), .SCW(16)) if1 ();
    hazard_scoreboard_if #(.REGW(REGW), .SCW(2))  if2 ();

    hazard_scoreboard #(.REGW(REGW), .MDLAT(MDLAT), .SCW(16)) dut  (.clk(clk), .reset_n(reset_n), .bus(if1));
    hazard_scoreboard #(.REGW(REGW), .MDLAT(MDLAT), .SCW(2))  dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    assign if2.rsD = if1.rsD;             assign if2.rtD = if1.rtD;
    assign if2.rsE = if1.rsE;             assign if2.rtE = if1.rtE;
    assign if2.writeregE = if1.writeregE; assign if2.writeregM = if1.writeregM;
    assign if2.writeregW = if1.writeregW; assign if2.regwriteE = if1.regwriteE;
    assign if2.regwriteM = if1.regwriteM; assign if2.regwriteW = if1.regwriteW;
    assign if2.memtoregE = if1.memtoregE; assign if2.memtoregM = if1.memtoregM;
    assign if2.branchD = if1.branchD;     assign if2.jumpD = if1.jumpD;
    assign if2.mdD = if1.mdD;             assign if2.mdstartE = if1.mdstartE;

    typedef struct {
        logic       fad, fbd;
        logic [1:0] fae, fbe;
        logic       stall, flush, busy, done;
        int         wr, sc16, sc2;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   nvec = 0;
    int   nerr = 0;

    // model state: m_k = cycle index since issue (1 = first cycle after the issue edge)
    bit   m_busy;
    int   m_k, m_wr, m_sc16, m_sc2;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] mfe(input int rs);
        int wm, ww;
        wm = int'(if1.writeregM);
        ww = int'(if1.writeregW);
        if (rs == 0) return 2'b00;
        if (if1.regwriteM && rs == wm) return 2'b10;
        if (if1.regwriteW && rs == ww) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        int rsd, rtd, rte, we, wm;
        bit lw, br, mi, mp, ms;
        rsd = int'(if1.rsD); rtd = int'(if1.rtD); rte = int'(if1.rtE);
        we  = int'(if1.writeregE); wm = int'(if1.writeregM);
        e.fad = (rsd != 0) && (rsd == wm) && if1.regwriteM;
        e.fbd = (rtd != 0) && (rtd == wm) && if1.regwriteM;
        e.fae = mfe(int'(if1.rsE));
        e.fbe = mfe(rte);
        e.done = m_busy && (m_k == MDLAT);
        lw = if1.memtoregE && (rte == rsd || rte == rtd);
        br = if1.branchD && ((if1.regwriteE && (we == rsd || we == rtd)) ||
                             (if1.memtoregM && (wm == rsd || wm == rtd)));
        mi = if1.mdstartE && we != 0 && (we == rsd || we == rtd);
        mp = m_busy && m_wr != 0 && (m_wr == rsd || m_wr == rtd);
        ms = if1.mdD && m_busy && !e.done;
        e.stall = lw | br | mi | mp | ms;
        e.flush = e.stall | if1.jumpD;
        e.busy  = m_busy;
        e.wr    = m_wr;
        e.sc16  = m_sc16;
        e.sc2   = m_sc2;
        return e;
    endfunction

    task automatic model_edge();
        if (cur.stall) begin
            if (m_sc16 < 65535) m_sc16++;
            if (m_sc2 < 3) m_sc2++;
        end
        if (if1.mdstartE) begin
            m_busy = 1; m_k = 1; m_wr = int'(if1.writeregE);
        end else if (cur.done) begin
            m_busy = 0;
        end else if (m_busy) begin
            m_k++;
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_wr = 0; m_sc16 = 0; m_sc2 = 0;
    endtask

    task automatic step();
        exp_t e;
        e = model_exp();
        q.push_back(e);
        cur = e;
        @(negedge clk);
        e = q.pop_front();
        chk("forwardaD", int'(if1.forwardaD), int'(e.fad));
        chk("forwardbD", int'(if1.forwardbD), int'(e.fbd));
        chk("forwardaE", int'(if1.forwardaE), int'(e.fae));
        chk("forwardbE", int'(if1.forwardbE), int'(e.fbe));
        chk("stallD",    int'(if1.stallD),    int'(e.stall));
        chk("stallF",    int'(if1.stallF),    int'(e.stall));
        chk("flushE",    int'(if1.flushE),    int'(e.flush));
        chk("mdbusy",    int'(if1.mdbusy),    int'(e.busy));
        chk("mddone",    int'(if1.mddone),    int'(e.done));
        chk("mdwritereg", int'(if1.mdwritereg), e.wr);
        chk("stallcnt",  int'(if1.stallcnt),  e.sc16);
        chk("stallcnt2", int'(if2.stallcnt),  e.sc2);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clr();
        if1.rsD = '0; if1.rtD = '0; if1.rsE = '0; if1.rtE = '0;
        if1.writeregE = '0; if1.writeregM = '0; if1.writeregW = '0;
        if1.regwriteE = 0; if1.regwriteM = 0; if1.regwriteW = 0;
        if1.memtoregE = 0; if1.memtoregM = 0; if1.branchD = 0; if1.jumpD = 0;
        if1.mdD = 0; if1.mdstartE = 0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_mdbusy"},   int'(if1.mdbusy),   0);
        chk({tag, "_mddone"},   int'(if1.mddone),   0);
        chk({tag, "_stallcnt"}, int'(if1.stallcnt), 0);
        chk({tag, "_mdwr"},     int'(if1.mdwritereg), 0);
    endtask

    initial begin
        int guard;
        clr();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_checks("rst");
        reset_n = 1'b1;
        #1;

        // forwarding: M priority, then W, then r0
        if1.rsE = 5; if1.rtE = 5; if1.writeregM = 5; if1.writeregW = 5;
        if1.regwriteM = 1; if1.regwriteW = 1;
        step();
        if1.regwriteM = 0; step();
        if1.rsE = 0; if1.rtE = 0; step();
        if1.rsD = 5; if1.rtD = 6; if1.regwriteM = 1; if1.writeregM = 6; step();

        // load-use stall, counter climbs
        clr();
        if1.memtoregE = 1; if1.rtE = 7; if1.rsD = 7;
        repeat (3) step();
        if1.jumpD = 1; if1.memtoregE = 0; step();

        // branch stalls from E and M
        clr();
        if1.branchD = 1; if1.regwriteE = 1; if1.writeregE = 4; if1.rtD = 4; step();
        if1.regwriteE = 0; if1.memtoregM = 1; if1.writeregM = 3; if1.rsD = 3; if1.rtD = 0; step();

        // randomised mixed traffic
        for (int i = 0; i < 40; i++) begin
            if1.rsD = REGW'($urandom_range(0, 3)); if1.rtD = REGW'($urandom_range(0, 3));
            if1.rsE = REGW'($urandom_range(0, 3)); if1.rtE = REGW'($urandom_range(0, 3));
            if1.writeregE = REGW'($urandom_range(0, 3));
            if1.writeregM = REGW'($urandom_range(0, 3));
            if1.writeregW = REGW'($urandom_range(0, 3));
            {if1.regwriteE, if1.regwriteM, if1.regwriteW} = 3'($urandom);
            {if1.memtoregE, if1.memtoregM, if1.branchD, if1.jumpD, if1.mdD} = 5'($urandom);
            if1.mdstartE = ($urandom_range(0, 5) == 0);
            step();
        end
        clr();
        repeat (MDLAT + 1) step();

        // multicycle issue to r9, dependent reader held in D
        if1.mdstartE = 1; if1.writeregE = 9; step();
        if1.mdstartE = 0; if1.writeregE = 0; if1.rsD = 9;
        repeat (MDLAT + 1) step();

        // structural stall, then back-to-back issue on the done cycle
        clr();
        if1.mdstartE = 1; if1.writeregE = 3; step();
        if1.mdstartE = 0; if1.writeregE = 0; if1.mdD = 1;
        guard = 0;
        while (!(m_busy && m_k == MDLAT) && guard < 20) begin
            step();
            guard++;
        end
        chk("done_reached_budget", int'(guard < 20), 1);
        if1.mdstartE = 1; if1.writeregE = 12; step();
        if1.mdstartE = 0; if1.writeregE = 0; if1.mdD = 0;
        repeat (MDLAT + 1) step();

        // reset mid-operation (cnt == 2)
        clr();
        if1.memtoregE = 1; if1.rtE = 1; if1.rsD = 1; step();
        clr();
        if1.mdstartE = 1; if1.writeregE = 9; step();
        if1.mdstartE = 0; if1.writeregE = 0; step();
        chk("pre_rst_busy", int'(if1.mdbusy), 1);
        reset_n = 1'b0;
        #1;
        reset_checks("async_rst");
        model_reset();
        reset_n = 1'b1;
        #1;
        repeat (MDLAT + 2) step();

        // 2-bit counter saturates: 1,2,3,3,3
        if1.memtoregE = 1; if1.rtE = 2; if1.rtD = 2;
        repeat (6) step();
        clr();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter REGW, default 5, register-address width.
REQ-002 SHALL provide parameter MDLAT, default 4, multicycle-unit latency in cycles; legal range 2..15.
REQ-003 SHALL provide parameter SCW, default 16, stall-counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 rsD, rtD, rsE, rtE  input  REGW each  source registers of the instructions in D and E.
REQ-007 writeregE, writeregM, writeregW  input  REGW each  destination registers of E, M and W.
REQ-008 regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, jumpD  input  1 each  pipeline control flags.
REQ-009 mdD  input  1  instruction in D is a multicycle (mult/div) op.
REQ-010 mdstartE  input  1  valid multicycle op in E; it issues at the next edge, with destination writeregE.
REQ-011 forwardaD, forwardbD  output  1 each  D-stage branch-compare forward select from M.
REQ-012 forwardaE, forwardbE  output  2 each  E-stage ALU forward select: 00 register file, 01 W, 10 M.
REQ-013 stallF, stallD, flushE  output  1 each  pipeline stall and flush controls.
REQ-014 mdbusy  output  1  multicycle op outstanding.
REQ-015 mddone  output  1  multicycle result valid this cycle.
REQ-016 mdwritereg  output  REGW  destination of the outstanding multicycle op.
REQ-017 stallcnt  output  SCW  saturating count of stalled cycles.

Function
REQ-018 forwardaD SHALL be 1 iff rsD!=0, rsD==writeregM and regwriteM; forwardbD is the same using rtD.
REQ-019 forwardaE SHALL be 00 when rsE==0, else 10 if rsE==writeregM and regwriteM, else 01 if rsE==writeregW and regwriteW, else 00 (M has priority); forwardbE is the same using rtE.
REQ-020 lwstall SHALL be memtoregE & (rtE==rsD | rtE==rtD).
REQ-021 brstall SHALL be branchD & ((regwriteE & writeregE matches rsD or rtD) | (memtoregM & writeregM matches rsD or rtD)).
REQ-022 mdissuestall SHALL be mdstartE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
REQ-023 mdpendstall SHALL be mdbusy & mdwritereg!=0 & (mdwritereg==rsD | mdwritereg==rtD); it stays asserted during the mddone cycle.
REQ-024 mdstructstall SHALL be mdD & mdbusy & !mddone.
REQ-025 stallD SHALL be the OR of all five stall terms; stallF SHALL equal stallD; flushE SHALL be stallD | jumpD; all three are combinational.
REQ-026 State: busy flag, down-counter cnt (4 bits), mdwritereg register.
REQ-027 On an edge with mdstartE=1: busy<=1, cnt<=MDLAT-1, mdwritereg<=writeregE.
REQ-028 On an edge with mdstartE=0, busy=1 and cnt!=0: cnt<=cnt-1.
REQ-029 On an edge with mdstartE=0 and mddone=1: busy<=0; cnt and mdwritereg hold.
REQ-030 mddone SHALL be busy & cnt==0 (combinational); mdbusy SHALL equal busy.
REQ-031 Latency: mddone SHALL assert exactly MDLAT cycles after the issue edge, for one cycle.
REQ-032 If mddone and mdstartE coincide, the new issue SHALL win: the counter reloads and the new destination is captured.
REQ-033 stallcnt SHALL increment on each edge where stallD=1 and SHALL saturate at 2^SCW-1 (no wrap).

Reset
REQ-034 reset_n=0 SHALL immediately clear busy, cnt, mdwritereg and stallcnt to 0, regardless of clk.
REQ-035 During reset, mdbusy=0 and mddone=0; combinational outputs follow their inputs; an op in flight is abandoned with no mddone.
REQ-036 After reset_n rises, the first state change SHALL occur on the following rising edge.

Verification
REQ-037 rsE=rtE=5, writeregM=writeregW=5, regwriteM=regwriteW=1 -> forwardaE=forwardbE=10; with regwriteM=0 -> 01; with rsE=rtE=0 -> 00.
REQ-038 memtoregE=1, rtE=7, rsD=7 -> stallD=stallF=flushE=1; stallcnt increments by 1 per stalled cycle.
REQ-039 MDLAT=4, mdstartE for one cycle with writeregE=9, then rsD=9 held -> mdbusy for 4 cycles, mddone in the 4th cycle, stallD=1 through the mddone cycle, 0 on the next cycle.
REQ-040 mdD=1 while busy -> stallD=1 until the mddone cycle; then mdstartE coinciding with mddone -> mdbusy stays 1, new mdwritereg captured, mddone 4 cycles later.
REQ-041 reset_n pulsed low mid-operation (cnt=2) -> mdbusy=0 and stallcnt=0 immediately; no mddone follows.
REQ-042 SCW=2 with stallD held for 5 cycles -> stallcnt goes 1, 2, 3, 3, 3.
